// File: rtl/regfile_multiport.sv
// Multi-port integer register file for the RV32 core.
// NRD combinational read ports with same-cycle write bypass, two posedge
// write ports (port 1 wins on address collision), a hardwired zero register,
// a per-register busy scoreboard, and a sequential clear engine that zeroes
// every entry after reset so the array needs no init file.
//
// Handshake: there is no per-transaction valid/ready here. "ready" is a level
// that is low while the clear engine runs; while it is low every write and
// alloc request is dropped and all read outputs are forced to zero. Once
// "ready" is high, requests presented on a rising edge take effect on that edge.
module regfile_multiport #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                we0,
    input  logic [AW-1:0]       wa0,
    input  logic [XLEN-1:0]     wd0,
    input  logic                we1,
    input  logic [AW-1:0]       wa1,
    input  logic [XLEN-1:0]     wd1,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    output logic                ready
);

    localparam int NREGS = 1 << AW;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    localparam logic [AW-1:0] LAST_IDX = '1;

    logic [0:0]      state;
    logic [AW-1:0]   clr_cnt;
    logic [XLEN-1:0] mem [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;
    logic            run;

    // The FSM state is directly observable through ready.
    assign run   = (state == ST_RUN);
    assign ready = run;

    // Clear engine: walk clr_cnt over every entry, then hand over to RUN.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + AW'(1);
            if (clr_cnt == LAST_IDX) begin
                state <= ST_RUN;
            end
        end
    end

    // Array update: zeroing during CLEAR, gated writes during RUN; port 1 is
    // assigned last so it wins when both ports hit the same entry.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            if (!run) begin
                mem[clr_cnt] <= '0;
            end else begin
                if (we0 && (wa0 != '0)) begin
                    mem[wa0] <= wd0;
                end
                if (we1 && (wa1 != '0)) begin
                    mem[wa1] <= wd1;
                end
            end
        end
    end

    // Next scoreboard value: writes retire, alloc sets last so it wins,
    // and the zero register is never busy.
    always_comb begin
        busy_next = busy;
        if (we0) begin
            busy_next[wa0] = 1'b0;
        end
        if (we1) begin
            busy_next[wa1] = 1'b0;
        end
        if (alloc_en) begin
            busy_next[alloc_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Scoreboard register: cleared by reset, frozen while clearing.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            busy <= '0;
        end else if (run) begin
            busy <= busy_next;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rdat;

        assign ra = rd_addr[i*AW +: AW];

        // Read mux: zero register / not ready give 0, else bypass then array.
        always_comb begin
            rdat = '0;
            if (run && (ra != '0)) begin
                if (we1 && (wa1 == ra)) begin
                    rdat = wd1;
                end else if (we0 && (wa0 == ra)) begin
                    rdat = wd0;
                end else begin
                    rdat = mem[ra];
                end
            end
        end

        assign rd_data[i*XLEN +: XLEN] = rdat;
        assign rd_busy[i]              = run & busy[ra];
    end

endmodule

// File: doc/regfile_multiport.md
Name:
regfile_multiport

Overview:
Parametrised integer register file for the RV32 core, the successor to the single-write, negedge-write bank. It provides NRD combinational read ports, two posedge write ports with write-to-read bypass, and a hardwired zero register. A per-register busy scoreboard supports hazard detection. A sequential clear engine zeroes the array after reset, so no memory-init file is needed.

Parameters:
XLEN, 32, data width in bits
AW, 5, address width; NREGS = 2**AW entries
NRD, 2, number of read ports (range 1..4)

Ports:
Clk  in  1  clock; all state changes on posedge
Rst  in  1  synchronous active-low reset
rd_addr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW]
rd_data  out  NRD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN]
rd_busy  out  NRD  scoreboard busy bit of each read address
we0  in  1  write enable, port 0
wa0  in  AW  write address, port 0
wd0  in  XLEN  write data, port 0
we1  in  1  write enable, port 1 (higher priority)
wa1  in  AW  write address, port 1
wd1  in  XLEN  write data, port 1
alloc_en  in  1  mark a destination register busy
alloc_addr  in  AW  register to mark busy
ready  out  1  high when the clear sequence is done and the file is usable

Behaviour:
- Reset: Clk rising with Rst=0 loads state CLEAR, sets clr_cnt=0, ready=0, and all busy bits=0.
  - Reset asserted mid-CLEAR restarts clr_cnt at 0.
  - Reset asserted in RUN discards all contents.
- FSM states: CLEAR and RUN.
- CLEAR: each cycle writes entry[clr_cnt]=0, then clr_cnt++.
  - Transition to RUN on the cycle clr_cnt==NREGS-1 is written.
  - The clear takes exactly NREGS cycles after Rst is released; ready rises on the following cycle edge.
  - While in CLEAR, we0, we1 and alloc_en are ignored.
  - While in CLEAR, rd_data=0 and rd_busy=0 on all ports.
- RUN: ready=1.
- Writes in RUN (posedge):
  - weN=1 and waN!=0 stores wdN into entry[waN].
  - Both ports write the same address: port 1 wins.
  - Writes to address 0 are dropped; entry 0 always reads 0.
- Reads are combinational with zero latency. For each port i with address ra:
  - ra==0 returns 0.
  - Otherwise, if we1 && wa1==ra, returns wd1 (same-cycle bypass).
  - Otherwise, if we0 && wa0==ra, returns wd0.
  - Otherwise returns entry[ra].
  - Bypass applies only in RUN.
- Scoreboard (posedge, RUN only):
  - alloc_en && alloc_addr!=0 sets busy[alloc_addr].
  - A write on either port clears busy[waN].
  - Alloc and write to the same register in the same cycle: alloc wins (busy=1).
  - busy[0] is constant 0.
  - rd_busy[i] = busy[rd_addr_i], the registered value with no bypass.
- Widths: all addresses are compared at the full AW width; no truncation or wrap is permitted.
- No X may propagate on rd_data after ready=1.

Test Plan:
- Hold Rst=0 for 3 cycles, then release with AW=5 -> ready=0 for 32 cycles, ready=1 on cycle 33; every address reads 0x00000000.
- In RUN, we0=1, wa0=5, wd0=0xDEADBEEF, rd_addr port0=5 in the same cycle -> rd_data0=0xDEADBEEF combinationally; the next cycle, with we0=0, it still reads 0xDEADBEEF.
- we0=1, wa0=7, wd0=0x11; we1=1, wa1=7, wd1=0x22 -> bypass read and later read of reg 7 both give 0x22.
- we1=1, wa1=0, wd1=0xFFFFFFFF -> reg 0 reads 0 in the same cycle and afterwards; rd_busy for address 0 stays 0.
- alloc_en=1, alloc_addr=9 -> rd_busy=1 on reg 9 next cycle.
  - A subsequent we0 to reg 9 clears busy next cycle.
  - alloc and we0 to reg 9 in the same cycle -> busy remains 1.
- Rst pulsed low at clr_cnt=10 during CLEAR -> clear restarts; ready rises 32 cycles after release.
  - A write issued during CLEAR (wa0=3, wd0=0x55) is ignored; reg 3 reads 0.
